// File: rtl/gps_scenario_sequencer_if.sv
// Host/core bundle for the GPS scenario sequencer: table writes, scenario control,
// the epoch pulse from the core, and the registered config/status going back out.
interface gps_scenario_sequencer_if #(
  parameter int N_ENTRIES = 4,
  parameter int NB_DWELL  = 8
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int DW = 22 + NB_DWELL;

  logic          wr_en_in;
  logic [AW-1:0] wr_addr_in;
  logic [DW-1:0] wr_data_in;
  logic [AW-1:0] last_idx_in;
  logic          loop_in;
  logic          start_in;
  logic          abort_in;
  logic          epoch_in;

  logic          core_ena_out;
  logic [4:0]    n_sat_out;
  logic [7:0]    doppler_out;
  logic [7:0]    snr_out;
  logic          signal_off_out;
  logic [AW-1:0] entry_idx_out;
  logic          busy_out;
  logic          done_out;

  // Pulses (start/abort/epoch/wr_en) are single-cycle strobes sampled at the
  // rising edge; there is no back-pressure, every strobe is taken when it arrives.
  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, last_idx_in, loop_in,
           start_in, abort_in, epoch_in,
    input  core_ena_out, n_sat_out, doppler_out, snr_out, signal_off_out,
           entry_idx_out, busy_out, done_out
  );

  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, last_idx_in, loop_in,
           start_in, abort_in, epoch_in,
    output core_ena_out, n_sat_out, doppler_out, snr_out, signal_off_out,
           entry_idx_out, busy_out, done_out
  );
endinterface

// File: rtl/gps_scenario_sequencer.sv
// Scenario scheduler: steps through a small config table, switching the generator
// core's config only on code-epoch pulses, with loop/stop and abort control.
module gps_scenario_sequencer #(
  parameter int N_ENTRIES = 4,
  parameter int NB_DWELL  = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  gps_scenario_sequencer_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int DW = 22 + NB_DWELL;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_table [N_ENTRIES];
  logic                  r_ena, w_ena_nxt;
  logic [4:0]            r_n_sat, w_n_sat_nxt;
  logic [7:0]            r_doppler, w_doppler_nxt;
  logic [7:0]            r_snr, w_snr_nxt;
  logic                  r_off, w_off_nxt;
  logic [AW-1:0]         r_idx, w_idx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [NB_DWELL-1:0]   r_dwell, w_dwell_nxt;
  logic [NB_DWELL-1:0]   r_rem, w_rem_nxt;

  logic                  w_load;
  logic                  w_clear;
  logic [AW-1:0]         w_load_idx;
  logic [DW-1:0]         w_entry;
  logic [NB_DWELL-1:0]   w_entry_dwell;

  assign w_entry       = r_table[w_load_idx];
  // A zero dwell plays as one epoch so rem never wraps.
  assign w_entry_dwell = (w_entry[DW-1:22] == '0) ? NB_DWELL'(1) : w_entry[DW-1:22];

  always_comb begin
    w_state_nxt   = r_state;
    w_ena_nxt     = r_ena;
    w_n_sat_nxt   = r_n_sat;
    w_doppler_nxt = r_doppler;
    w_snr_nxt     = r_snr;
    w_off_nxt     = r_off;
    w_idx_nxt     = r_idx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_dwell_nxt   = r_dwell;
    w_rem_nxt     = r_rem;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    w_load_idx    = r_idx;

    case (r_state)
      S_IDLE: begin
        if (bus.start_in && !bus.abort_in) begin
          w_load      = 1'b1;
          w_load_idx  = '0;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.abort_in) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.epoch_in) begin
          w_rem_nxt   = r_dwell;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort_in) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.epoch_in) begin
          if (r_rem == NB_DWELL'(1)) begin
            if (r_idx < bus.last_idx_in) begin
              w_load     = 1'b1;
              w_load_idx = r_idx + AW'(1);
            end else if (bus.loop_in) begin
              w_load     = 1'b1;
              w_load_idx = '0;
            end else begin
              w_clear     = 1'b1;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end
          end else begin
            w_rem_nxt = r_rem - NB_DWELL'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_ena_nxt     = 1'b1;
      w_busy_nxt    = 1'b1;
      w_n_sat_nxt   = w_entry[4:0];
      w_doppler_nxt = w_entry[12:5];
      w_snr_nxt     = w_entry[20:13];
      w_off_nxt     = w_entry[21];
      w_idx_nxt     = w_load_idx;
      w_dwell_nxt   = w_entry_dwell;
      w_rem_nxt     = w_entry_dwell;
    end
    if (w_clear) begin
      w_ena_nxt     = 1'b0;
      w_busy_nxt    = 1'b0;
      w_n_sat_nxt   = '0;
      w_doppler_nxt = '0;
      w_snr_nxt     = '0;
      w_off_nxt     = 1'b1;
      w_idx_nxt     = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_ENTRIES; i++) r_table[i] <= '0;
      r_state   <= S_IDLE;
      r_ena     <= 1'b0;
      r_n_sat   <= '0;
      r_doppler <= '0;
      r_snr     <= '0;
      r_off     <= 1'b1;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dwell   <= NB_DWELL'(1);
      r_rem     <= NB_DWELL'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_ena     <= w_ena_nxt;
      r_n_sat   <= w_n_sat_nxt;
      r_doppler <= w_doppler_nxt;
      r_snr     <= w_snr_nxt;
      r_off     <= w_off_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dwell   <= w_dwell_nxt;
      r_rem     <= w_rem_nxt;
      // The load above reads the pre-write table, so a write to the active
      // entry only shows up at its next load.
      if (bus.wr_en_in) r_table[bus.wr_addr_in] <= bus.wr_data_in;
    end
  end

  assign bus.core_ena_out   = r_ena;
  assign bus.n_sat_out      = r_n_sat;
  assign bus.doppler_out    = r_doppler;
  assign bus.snr_out        = r_snr;
  assign bus.signal_off_out = r_off;
  assign bus.entry_idx_out  = r_idx;
  assign bus.busy_out       = r_busy;
  assign bus.done_out       = r_done;
  assign o_dbg_state        = r_state;
endmodule
